// File: rtl/fpu_mul_result_packer_if.sv
// ============================================================================
// fpu_mul_result_packer_if
// Product-in / result-out handshake bundle of the FP32 multiplier packer.
// master : upstream product source and result consumer
// slave  : the packer itself
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fpu_mul_result_packer_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [47:0] in_mant;
   logic [1:0]  in_class;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, in_class, out_ready,
      input  in_ready, out_valid, out_res
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, in_class, out_ready,
      output in_ready, out_valid, out_res
   );
endinterface

`default_nettype wire

// File: rtl/fpu_mul_result_packer.sv
// ============================================================================
// fpu_mul_result_packer
// Normalizes the 48-bit significand product, rounds to nearest-even, detects
// overflow/underflow and packs an IEEE-754 single. Two pipeline stages with
// valid/ready backpressure and sticky exception flags.
// Optional: FPU_PACK_OPCNT_EN builds the retired-result counter (op_count).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_mul_result_packer #(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   fpu_mul_result_packer_if.slave bus,
   input  logic                 flag_clr,
   output logic                 flag_overflow,
   output logic                 flag_underflow,
   output logic                 flag_inexact,
   output logic                 flag_invalid,
   output logic [CNT_W-1:0]     op_count
);

   localparam logic [1:0] CLS_ZERO = 2'b01;
   localparam logic [1:0] CLS_INF  = 2'b10;
   localparam logic [1:0] CLS_NAN  = 2'b11;

   // Stage 1 registers: normalized significand, guard/sticky, adjusted exponent
   logic               s1_valid;
   logic               s1_sign;
   logic signed [10:0] s1_exp;
   logic [22:0]        s1_sig;
   logic               s1_g;
   logic               s1_s;
   logic [1:0]         s1_class;

   // Stage 2 registers: packed result
   logic               s2_valid;
   logic [31:0]        s2_res;

   logic s2_ready;
   logic s1_ready;
   logic load1;
   logic load2;

   assign s2_ready     = !s2_valid || bus.out_ready;
   assign s1_ready     = !s1_valid || s2_ready;
   assign load1        = bus.in_valid && s1_ready;
   assign load2        = s1_valid && s2_ready;
   assign bus.in_ready = s1_ready;
   assign bus.out_valid = s2_valid;
   assign bus.out_res  = s2_res;

   logic               n_hi;
   logic [22:0]        n_sig;
   logic               n_g;
   logic               n_s;
   logic signed [10:0] n_exp;

   // Normalize: a product in [2,4) shifts one place right and bumps the exponent
   always_comb begin
      n_hi  = bus.in_mant[47];
      n_sig = n_hi ? bus.in_mant[46:24] : bus.in_mant[45:23];
      n_g   = n_hi ? bus.in_mant[23]    : bus.in_mant[22];
      n_s   = n_hi ? (|bus.in_mant[22:0]) : (|bus.in_mant[21:0]);
      n_exp = $signed({bus.in_exp[9], bus.in_exp}) + $signed({10'd0, n_hi});
   end

   // Stage 1 capture on an accepted product
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_exp   <= '0;
         s1_sig   <= '0;
         s1_g     <= 1'b0;
         s1_s     <= 1'b0;
         s1_class <= '0;
      end else begin
         s1_valid <= load1 || (s1_valid && !load2);
         if (load1) begin
            s1_sign  <= bus.in_sign;
            s1_exp   <= n_exp;
            s1_sig   <= n_sig;
            s1_g     <= n_g;
            s1_s     <= n_s;
            s1_class <= bus.in_class;
         end
      end
   end

   logic               r_inc;
   logic [23:0]        r_sum;
   logic signed [10:0] r_exp;
   logic [31:0]        p_res;
   logic               p_ovf;
   logic               p_unf;
   logic               p_inx;
   logic               p_inv;

   // Round to nearest-even and pack; special classes bypass rounding
   always_comb begin
      r_inc = s1_g && (s1_s || s1_sig[0]);
      r_sum = {1'b0, s1_sig} + {23'd0, r_inc};
      // carry-out leaves the low 23 bits zero, which is the renormalized field
      r_exp = s1_exp + $signed({10'd0, r_sum[23]});
      p_res = '0;
      p_ovf = 1'b0;
      p_unf = 1'b0;
      p_inx = 1'b0;
      p_inv = 1'b0;
      case (s1_class)
         CLS_ZERO: p_res = {s1_sign, 31'd0};
         CLS_INF:  p_res = {s1_sign, 8'hFF, 23'd0};
         CLS_NAN: begin
            p_res = 32'h7FC0_0000;
            p_inv = 1'b1;
         end
         default: begin
            p_inx = s1_g || s1_s;
            if (r_exp >= 11'sd255) begin
               p_res = {s1_sign, 8'hFF, 23'd0};
               p_ovf = 1'b1;
               p_inx = 1'b1;
            end else if (r_exp <= 11'sd0) begin
               p_res = {s1_sign, 31'd0};
               p_unf = 1'b1;
               p_inx = 1'b1;
            end else begin
               p_res = {s1_sign, r_exp[7:0], r_sum[22:0]};
            end
         end
      endcase
   end

   // Stage 2 output register, held while the consumer stalls
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_res   <= '0;
      end else begin
         s2_valid <= load2 || (s2_valid && !bus.out_ready);
         if (load2) begin
            s2_res <= p_res;
         end
      end
   end

   // Sticky flags; a clear wins over a set arriving in the same cycle
   always_ff @(posedge clk) begin
      if (reset || flag_clr) begin
         flag_overflow  <= 1'b0;
         flag_underflow <= 1'b0;
         flag_inexact   <= 1'b0;
         flag_invalid   <= 1'b0;
      end else if (load2) begin
         flag_overflow  <= flag_overflow  || p_ovf;
         flag_underflow <= flag_underflow || p_unf;
         flag_inexact   <= flag_inexact   || p_inx;
         flag_invalid   <= flag_invalid   || p_inv;
      end
   end

`ifdef FPU_PACK_OPCNT_EN
   logic [CNT_W-1:0] cnt;

   // Count retired results, wrapping naturally at the counter width
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (s2_valid && bus.out_ready) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign op_count = cnt;
`else
   assign op_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpu_mul_result_packer.sv
// ============================================================================
// tb_fpu_mul_result_packer
// Scoreboard bench: stimulus pushes expected results from an arithmetic
// reference model; a monitor pops and compares on every retired result.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_mul_result_packer;
   logic        clk = 1'b0;
   logic        reset;
   logic        flag_clr;
   logic        flag_overflow, flag_underflow, flag_inexact, flag_invalid;
   logic [15:0] op_count;

   fpu_mul_result_packer_if bus();

   fpu_mul_result_packer #(.CNT_W(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus),
      .flag_clr       (flag_clr),
      .flag_overflow  (flag_overflow),
      .flag_underflow (flag_underflow),
      .flag_inexact   (flag_inexact),
      .flag_invalid   (flag_invalid),
      .op_count       (op_count)
   );

   always #5 clk = ~clk;

   logic [31:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_retired = 0;
   int          rdy_mode = 0;      // 0 always ready, 1 random, 2 stalled
   logic [3:0]  acc_flags = 4'd0;  // {ovf, unf, inx, inv} expected since last clear

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference: integer rounding of the product, independent of bit slicing
   function automatic logic [35:0] model(input logic s, input logic [9:0] e_in,
                                         input logic [47:0] m, input logic [1:0] c);
      longint unsigned mv, keep, rem, half;
      int sh, e;
      logic inx;
      case (c)
         2'b01: return {4'b0000, s, 31'd0};
         2'b10: return {4'b0000, s, 8'hFF, 23'd0};
         2'b11: return {4'b0001, 32'h7FC00000};
         default: ;
      endcase
      mv   = 64'(m);
      sh   = m[47] ? 24 : 23;
      e    = int'($signed(e_in)) + (m[47] ? 1 : 0);
      keep = mv >> sh;
      rem  = mv - (keep << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep++;
      if (keep == (64'd1 << 24)) begin
         keep = 64'd1 << 23;
         e++;
      end
      inx = (rem != 0);
      if (e >= 255) return {4'b1010, s, 8'hFF, 23'd0};
      if (e <= 0)   return {4'b0110, s, 31'd0};
      return {2'b00, inx, 1'b0, s, e[7:0], keep[22:0]};
   endfunction

   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = ($urandom_range(0, 3) != 0);
         default: bus.out_ready = 1'b0;
      endcase
   end

   // Monitor: pops the scoreboard on each retirement, checks hold during stalls
   initial begin
      logic        prev_stall;
      logic [31:0] prev_res;
      logic [31:0] e;
      prev_stall = 1'b0;
      prev_res   = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 1'b0;
            n_retired  = 0;
         end else begin
            if (prev_stall)
               check("stall_hold", {31'd0, bus.out_valid, bus.out_res}, {31'd0, 1'b1, prev_res});
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_result: got %h, expected none", bus.out_res);
               end else begin
                  e = exp_q.pop_front();
                  check("result", {32'd0, bus.out_res}, {32'd0, e});
               end
               n_retired++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res   = bus.out_res;
         end
      end
   end

   task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m, input logic [1:0] c);
      int budget = 0;
      logic [35:0] r;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sign  = s;
      bus.in_exp   = e;
      bus.in_mant  = m;
      bus.in_class = c;
      while (!bus.in_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 200) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      r = model(s, e, m, c);
      exp_q.push_back(r[31:0]);
      acc_flags = acc_flags | r[35:32];
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int budget = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 500) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      end
   endtask

   task automatic clear_flags();
      @(negedge clk);
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
      acc_flags = 4'd0;
   endtask

   function automatic logic [63:0] flags_now();
      return {60'd0, flag_overflow, flag_underflow, flag_inexact, flag_invalid};
   endfunction

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      exp_q.delete();
      acc_flags = 4'd0;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   typedef struct {
      logic        s;
      logic [9:0]  e;
      logic [47:0] m;
      logic [1:0]  c;
   } vec_t;

   vec_t dir[12];

   initial begin
      reset        = 1'b1;
      flag_clr     = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sign  = 1'b0;
      bus.in_exp   = '0;
      bus.in_mant  = '0;
      bus.in_class = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_out_res",   {32'd0, bus.out_res}, 64'd0);
      check("rst_flags",     flags_now(), 64'd0);
      check("rst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
      check("rst_op_count",  {48'd0, op_count}, 64'd0);

      // Latency: visible after the second edge following acceptance
      send(1'b0, 10'd127, 48'h900000000000, 2'b00);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("lat_not_yet", {63'd0, bus.out_valid}, 64'd0);
      @(negedge clk);
      check("lat_valid", {63'd0, bus.out_valid}, 64'd1);
      check("lat_res", {32'd0, bus.out_res}, 64'h40100000);
      drain();
      check("no_flags_2p25", flags_now(), 64'd0);

      // Directed vectors, flags checked per result
      dir[0]  = '{1'b0, 10'd127,  48'h900000000000, 2'b00};
      dir[1]  = '{1'b0, 10'd127,  48'h400000C00000, 2'b00};
      dir[2]  = '{1'b0, 10'd127,  48'h400000400000, 2'b00};
      dir[3]  = '{1'b1, 10'd254,  48'hFFFFFFFFFFFF, 2'b00};
      dir[4]  = '{1'b0, 10'h3FB,  48'h800000000000, 2'b00};
      dir[5]  = '{1'b0, 10'h3FF,  48'h800000000000, 2'b00};
      dir[6]  = '{1'b0, 10'd0,    48'h800000000000, 2'b00};
      dir[7]  = '{1'b0, 10'd100,  48'hFFFFFFFFFFFF, 2'b00};
      dir[8]  = '{1'b0, 10'd253,  48'h7FFFFFFFFFFF, 2'b00};
      dir[9]  = '{1'b0, 10'd0,    48'h0,            2'b11};
      dir[10] = '{1'b1, 10'd0,    48'h0,            2'b10};
      dir[11] = '{1'b0, 10'd0,    48'h0,            2'b01};
      for (int i = 0; i < 12; i++) begin
         clear_flags();
         send(dir[i].s, dir[i].e, dir[i].m, dir[i].c);
         idle();
         drain();
         check($sformatf("dir_flags_%0d", i), flags_now(), {60'd0, acc_flags});
      end

      // Explicit clear after an underflow
      clear_flags();
      send(1'b0, 10'h3FB, 48'h800000000000, 2'b00);
      idle();
      drain();
      check("unf_set", {63'd0, flag_underflow}, 64'd1);
      clear_flags();
      check("clr_all", flags_now(), 64'd0);

      // Clear coincident with a NaN entering the output register
      send(1'b0, 10'd0, 48'h0, 2'b11);
      @(negedge clk);
      bus.in_valid = 1'b0;
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
      drain();
      check("clr_priority", flags_now(), 64'd0);
      acc_flags = 4'd0;

      // Randomized traffic with random backpressure
      rdy_mode = 1;
      for (int i = 0; i < 300; i++) begin
         int          ei;
         logic [47:0] m;
         logic [1:0]  c;
         ei = int'($urandom_range(0, 300)) - 20;
         m  = {$urandom(), $urandom()};
         if (m[47:46] == 2'b00) m[46] = 1'b1;
         c  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         send(1'($urandom_range(0, 1)), ei[9:0], m, c);
         if ($urandom_range(0, 4) == 0) idle();
      end
      idle();
      drain();
      check("rand_flags", flags_now(), {60'd0, acc_flags});
      rdy_mode = 0;
      clear_flags();

      // Stall mid-stream: fill both stages, hold three cycles, resume
      rdy_mode = 2;
      @(posedge clk);
      #3;
      send(1'b0, 10'd127, 48'h900000000000, 2'b00);
      send(1'b1, 10'd130, 48'h400000C00000, 2'b00);
      idle();
      check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      repeat (3) @(negedge clk);
      rdy_mode = 0;
      send(1'b0, 10'd120, 48'hC00000000001, 2'b00);
      send(1'b1, 10'd127, 48'h400000400000, 2'b00);
      idle();
      drain();
      check("stream_empty", {32'd0, 32'(exp_q.size())}, 64'd0);

      // Reset with both stages occupied
      rdy_mode = 2;
      @(posedge clk);
      #3;
      send(1'b1, 10'd254, 48'hFFFFFFFFFFFF, 2'b00);
      send(1'b0, 10'd127, 48'h900000000000, 2'b00);
      idle();
      check("pre_rst_ovf", {63'd0, flag_overflow}, 64'd1);
      do_reset();
      rdy_mode = 0;
      @(negedge clk);
      check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("mid_rst_flags", flags_now(), 64'd0);
      check("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      repeat (4) @(negedge clk);
      check("mid_rst_nothing", {63'd0, bus.out_valid}, 64'd0);

`ifdef FPU_PACK_OPCNT_EN
      for (int i = 0; i < 5; i++) send(1'b0, 10'd127, 48'h900000000000, 2'b00);
      idle();
      drain();
      check("op_count_5", {48'd0, op_count}, 64'd5);
`endif

      check("final_queue", {32'd0, 32'(exp_q.size())}, 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, expected finish before limit");
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire
